// File: rtl/count_frame_pkg.sv
// Shared types and sizing helpers for the counter-snapshot serial transmitter.
package count_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Free-running bit-period timer; bit_tick marks the last cycle of each bit period.
module tx_bit_timer
    import count_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int TW = cnt_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (clear || bit_tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/count_frame_tx.sv
// Serialises a WIDTH-bit counter snapshot into a UART-style frame:
// start(0), data LSB first, optional even parity, stop(1).
module count_frame_tx
    import count_frame_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int IW = cnt_width(WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             bit_tick;
    logic             timer_clear;

    // Timer restarts on every state entry and is held at zero while idle.
    assign timer_clear = (state_q == IDLE) || (state_d != state_q);

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = START;
            START:   if (bit_tick) state_d = DATA;
            DATA:    if (bit_tick && idx_q == LAST_IDX)
                         state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_tick) state_d = STOP;
            STOP:    if (bit_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word and its parity are captured once on accept; later in_data is ignored.
    always_comb begin
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        if (state_q == IDLE && in_valid) begin
            shift_d = in_data;
            par_d   = ^in_data;
            idx_d   = '0;
        end else if (state_q == DATA && bit_tick) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        busy       = (state_q != IDLE);
        frame_done = (state_q == STOP) && bit_tick && !rst;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
            PARITY:  tx = par_q;
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_count_frame_tx.sv
// Directed bench for count_frame_tx: three instances cover parity off/on and one clock per bit.
module tb_count_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  tx;
    logic [2:0]  busy;
    logic [2:0]  frame_done;
    logic [15:0] in_data [3];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_frame_tx #(.WIDTH(16), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    count_frame_tx #(.WIDTH(16), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    count_frame_tx #(.WIDTH(16), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(frame_done[2]));

    // Present w for one edge; returns at the sample point of cycle N+1.
    task automatic send(input int d, input logic [15:0] w);
        in_valid[d] = 1'b1;
        in_data[d]  = w;
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    // Starting in cycle N+1, walk the whole frame and the first idle cycle after it.
    task automatic run_frame(input int d, input logic [15:0] w, input int clks,
                             input int par, input string name);
        logic exp_bits [0:18];
        int   nb;
        int   f;
        logic et;
        nb = 18 + par;
        f  = nb * clks;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 16; i++) exp_bits[1+i] = w[i];
        exp_bits[17] = par ? ^w : 1'b1;
        exp_bits[18] = 1'b1;
        for (int c = 1; c <= f; c++) begin
            et = exp_bits[(c-1)/clks];
            checks++;
            if (tx[d] !== et) begin
                errors++;
                $display("FAIL %s tx cyc N+%0d: got %b want %b", name, c, tx[d], et);
            end
            checks++;
            if (frame_done[d] !== 1'(c == f)) begin
                errors++;
                $display("FAIL %s frame_done cyc N+%0d: got %b want %b", name, c, frame_done[d], c == f);
            end
            checks++;
            if ({busy[d], in_ready[d]} !== 2'b10) begin
                errors++;
                $display("FAIL %s busy/ready cyc N+%0d: got %b%b want 10", name, c, busy[d], in_ready[d]);
            end
            @(negedge clk);
        end
        checks++;
        if ({tx[d], busy[d], in_ready[d], frame_done[d]} !== 4'b1010) begin
            errors++;
            $display("FAIL %s after-frame cyc N+%0d tx/busy/ready/done: got %b%b%b%b want 1010",
                     name, f + 1, tx[d], busy[d], in_ready[d], frame_done[d]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({tx, busy, in_ready, frame_done} !== {3'b111, 3'b000, 3'b111, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got tx=%b busy=%b ready=%b done=%b want 111 000 111 000",
                     tx, busy, in_ready, frame_done);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, in_ready, frame_done} !== {3'b111, 3'b000, 3'b111, 3'b000}) begin
                errors++;
                $display("FAIL idle cyc %0d: got tx=%b busy=%b ready=%b done=%b want 111 000 111 000",
                         c, tx, busy, in_ready, frame_done);
            end
        end
    endtask

    task automatic test_basic();
        send(0, 16'h00A5);
        in_data[0] = 16'hFFFF;
        run_frame(0, 16'h00A5, 4, 0, "basic_a5");
        @(negedge clk);
        send(0, 16'h0000);
        run_frame(0, 16'h0000, 4, 0, "zeros");
    endtask

    task automatic test_parity();
        @(negedge clk);
        send(1, 16'h0007);
        run_frame(1, 16'h0007, 4, 1, "parity_07");
        @(negedge clk);
        send(1, 16'h0003);
        run_frame(1, 16'h0003, 4, 1, "parity_03");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 16'h0001;
        @(negedge clk);
        in_data[0]  = 16'h0002;
        run_frame(0, 16'h0001, 4, 0, "b2b_first");
        @(negedge clk);
        in_valid[0] = 1'b0;
        run_frame(0, 16'h0002, 4, 0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        send(0, 16'h00A5);
        repeat (25) @(negedge clk);
        checks++;
        if ({tx[0], busy[0]} !== 2'b11) begin
            errors++;
            $display("FAIL mid_bit5 tx/busy: got %b%b want 11", tx[0], busy[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx[0], busy[0], in_ready[0], frame_done[0]} !== 4'b1010) begin
            errors++;
            $display("FAIL mid_reset tx/busy/ready/done: got %b%b%b%b want 1010",
                     tx[0], busy[0], in_ready[0], frame_done[0]);
        end
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({tx[0], busy[0], frame_done[0]} !== 3'b100) begin
                errors++;
                $display("FAIL post_reset idle cyc %0d: got %b%b%b want 100", c, tx[0], busy[0], frame_done[0]);
            end
        end
        send(0, 16'h1234);
        run_frame(0, 16'h1234, 4, 0, "after_reset");
    endtask

    task automatic test_fast();
        @(negedge clk);
        send(2, 16'hFFFF);
        run_frame(2, 16'hFFFF, 1, 0, "clk1_ffff");
        @(negedge clk);
        send(2, 16'h8001);
        run_frame(2, 16'h8001, 1, 0, "clk1_8001");
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = '0;
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_fast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
